// File: rtl/resize_shift_ctrl_if.sv
// rtl/resize_shift_ctrl_if.sv - control/status bundle between the resize datapath and its gain controller
interface resize_shift_ctrl_if #(
    parameter int SHIFT_WIDTH = 5
) ();
    logic                   en;
    logic                   din_valid;
    logic                   sync_in;
    logic                   warning;
    logic                   force_en;
    logic [SHIFT_WIDTH-1:0] force_val;
    logic [SHIFT_WIDTH-1:0] shift_out;
    logic                   shift_update;
    logic [15:0]            ovf_count;
    logic                   at_limit;

    modport master (
        output en, din_valid, sync_in, warning, force_en, force_val,
        input  shift_out, shift_update, ovf_count, at_limit
    );

    modport slave (
        input  en, din_valid, sync_in, warning, force_en, force_val,
        output shift_out, shift_update, ovf_count, at_limit
    );
endinterface

// File: rtl/resize_shift_ctrl.sv
// rtl/resize_shift_ctrl.sv - closed-loop shift controller for the resize stage
module resize_shift_ctrl #(
    parameter int SHIFT_WIDTH = 5,
    parameter int SHIFT_MIN   = -8,
    parameter int SHIFT_MAX   = 8,
    parameter int SHIFT_INIT  = 6,
    parameter int WINDOW_LEN  = 1024,
    parameter int OVF_THRESH  = 4,
    parameter int QUIET_WINS  = 8,
    parameter int HOLDOFF     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    resize_shift_ctrl_if.slave  bus
);
    localparam int SCW = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
    localparam int QCW = $clog2(QUIET_WINS + 1);
    localparam int HCW = $clog2(HOLDOFF + 1);

    localparam logic signed [SHIFT_WIDTH-1:0] MIN_V  = SHIFT_WIDTH'(SHIFT_MIN);
    localparam logic signed [SHIFT_WIDTH-1:0] MAX_V  = SHIFT_WIDTH'(SHIFT_MAX);
    localparam logic signed [SHIFT_WIDTH-1:0] INIT_V = SHIFT_WIDTH'(SHIFT_INIT);
    localparam logic signed [SHIFT_WIDTH-1:0] ONE_V  = SHIFT_WIDTH'(1);

    typedef enum logic [1:0] {ACCUM, EVAL, WAIT_SYNC, SETTLE} state_t;

    state_t                        state_q;
    logic signed [SHIFT_WIDTH-1:0] shift_q;
    logic signed [SHIFT_WIDTH-1:0] shift_d;
    logic signed [SHIFT_WIDTH-1:0] pending_q;
    logic signed [SHIFT_WIDTH-1:0] force_clamped;
    logic                          shift_update_q;
    logic [15:0]                   ovf_count_q;
    logic [15:0]                   warn_q;
    logic [SCW-1:0]                sample_q;
    logic [QCW-1:0]                quiet_q;
    logic [HCW-1:0]                hold_q;

    always_comb begin
        force_clamped = $signed(bus.force_val);
        if ($signed(bus.force_val) < MIN_V)
            force_clamped = MIN_V;
        else if ($signed(bus.force_val) > MAX_V)
            force_clamped = MAX_V;
    end

    // Priority: force overrides disable, disable overrides a loop commit.
    always_comb begin
        shift_d = shift_q;
        if (bus.force_en)
            shift_d = force_clamped;
        else if (!bus.en)
            shift_d = INIT_V;
        else if (state_q == WAIT_SYNC && bus.sync_in)
            shift_d = pending_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACCUM;
            shift_q        <= INIT_V;
            pending_q      <= INIT_V;
            shift_update_q <= 1'b0;
            ovf_count_q    <= '0;
            warn_q         <= '0;
            sample_q       <= '0;
            quiet_q        <= '0;
            hold_q         <= '0;
        end else begin
            shift_q        <= shift_d;
            shift_update_q <= (shift_d != shift_q);
            if (bus.force_en || !bus.en) begin
                state_q   <= ACCUM;
                pending_q <= INIT_V;
                warn_q    <= '0;
                sample_q  <= '0;
                quiet_q   <= '0;
                hold_q    <= '0;
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (bus.din_valid)
                            sample_q <= sample_q + 1'b1;
                        if (bus.warning && warn_q != 16'hFFFF)
                            warn_q <= warn_q + 16'd1;
                        if (bus.din_valid && sample_q == SCW'(WINDOW_LEN - 1))
                            state_q <= EVAL;
                    end
                    EVAL: begin
                        ovf_count_q <= warn_q;
                        warn_q      <= '0;
                        sample_q    <= '0;
                        state_q     <= ACCUM;
                        if (warn_q >= 16'(OVF_THRESH)) begin
                            quiet_q <= '0;
                            if (shift_q > MIN_V) begin
                                pending_q <= shift_q - ONE_V;
                                state_q   <= WAIT_SYNC;
                            end
                        end else if (warn_q == 16'd0) begin
                            if (quiet_q == QCW'(QUIET_WINS - 1)) begin
                                quiet_q <= '0;
                                if (shift_q < MAX_V) begin
                                    pending_q <= shift_q + ONE_V;
                                    state_q   <= WAIT_SYNC;
                                end
                            end else begin
                                quiet_q <= quiet_q + 1'b1;
                            end
                        end else begin
                            quiet_q <= '0;
                        end
                    end
                    WAIT_SYNC: begin
                        if (bus.sync_in) begin
                            hold_q  <= '0;
                            state_q <= SETTLE;
                        end
                    end
                    default: begin
                        // Datapath still carries samples resized with the old gain.
                        if (hold_q == HCW'(HOLDOFF - 1)) begin
                            hold_q  <= '0;
                            state_q <= ACCUM;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.shift_out    = shift_q;
    assign bus.shift_update = shift_update_q;
    assign bus.ovf_count    = ovf_count_q;
    assign bus.at_limit     = (shift_q == MIN_V) || (shift_q == MAX_V);
endmodule
